// File: rtl/i2s_sample_capture.sv
// I2S receiver: oversamples bclk/lrclk/sdata in the clk domain and captures one
// channel's MSB-first words, with optional decimation and short-slot detection.
`timescale 1ns/1ps
module i2s_sample_capture #(
    parameter int WORD_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int DECIM      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  channel_sel,
    input  logic                  bclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [WORD_WIDTH-1:0] sample_data,
    output logic                  sample,
    output logic                  frame_error
);

    localparam int CW = $clog2(SLOT_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);
    localparam logic [7:0]    DEC_LAST = 8'(DECIM - 1);

    typedef enum logic [2:0] {IDLE, SYNC, SKIP, SHIFT, HOLD} state_t;

    logic [2:0] bclk_sync_q;
    logic [1:0] lrclk_sync_q;
    logic [1:0] sdata_sync_q;
    logic       lr_last_q;
    logic       lr_seen_q;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            dec_q, dec_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  sample_q, sample_d;
    logic                  ferr_q, ferr_d;
    logic                  slot_ch_q, slot_ch_d;
    logic                  sel_q, sel_d;

    logic                  bit_tick;
    logic                  lr_now;
    logic                  sd_now;
    logic                  lr_edge;
    logic [WORD_WIDTH-1:0] word_next;

    // bclk edge is taken between stages 2 and 3, so lrclk/sdata stage 2 line up with it
    assign bit_tick  = bclk_sync_q[1] & ~bclk_sync_q[2];
    assign lr_now    = lrclk_sync_q[1];
    assign sd_now    = sdata_sync_q[1];
    assign lr_edge   = bit_tick & lr_seen_q & (lr_now != lr_last_q);
    assign word_next = {shift_q[WORD_WIDTH-2:0], sd_now};

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
            sdata_sync_q <= '0;
            lr_last_q    <= 1'b0;
            lr_seen_q    <= 1'b0;
        end else begin
            bclk_sync_q  <= {bclk_sync_q[1:0], bclk};
            lrclk_sync_q <= {lrclk_sync_q[0], lrclk};
            sdata_sync_q <= {sdata_sync_q[0], sdata};
            if (bit_tick) begin
                lr_last_q <= lr_now;
                lr_seen_q <= 1'b1;
            end
        end
    end

    // The tick that reveals an lrclk transition carries the one-bit I2S delay
    // slot; SKIP absorbs it so the next tick in SHIFT is the MSB.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        dec_d     = dec_q;
        data_d    = data_q;
        sample_d  = 1'b0;
        ferr_d    = 1'b0;
        slot_ch_d = lr_edge ? lr_now : slot_ch_q;
        sel_d     = lr_edge ? channel_sel : sel_q;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = SYNC;
                SYNC: if (lr_edge) state_d = SKIP;
                SKIP: begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (lr_edge) begin
                        ferr_d  = 1'b1;
                        state_d = SKIP;
                    end else if (bit_tick) begin
                        shift_d = word_next;
                        cnt_d   = cnt_q + CW'(1);
                        if (cnt_q == LAST_BIT) begin
                            state_d = HOLD;
                            if (slot_ch_q == sel_q) begin
                                dec_d = (dec_q >= DEC_LAST) ? 8'd0 : dec_q + 8'd1;
                                if (dec_q == 8'd0) begin
                                    data_d   = word_next;
                                    sample_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                HOLD: if (lr_edge) state_d = SKIP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            dec_q     <= '0;
            data_q    <= '0;
            sample_q  <= 1'b0;
            ferr_q    <= 1'b0;
            slot_ch_q <= 1'b0;
            sel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            dec_q     <= dec_d;
            data_q    <= data_d;
            sample_q  <= sample_d;
            ferr_q    <= ferr_d;
            slot_ch_q <= slot_ch_d;
            sel_q     <= sel_d;
        end
    end

    assign sample_data = data_q;
    assign sample      = sample_q;
    assign frame_error = ferr_q;

endmodule
